// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment bus monitor: active-low segment codes
// (g..a, bit 6 = g) for hex 0-F, the blank pattern and the idle anode word.
package sseg_pkg;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_IDLE   = 4'b1111;

   function automatic logic is_one_cold(input logic [3:0] a);
      return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
   endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the seven-segment encoder: maps an active-low
// segment pattern back to its hex nibble and flags patterns outside the table.
module seg7_to_hex
   import sseg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       legal
);

   always_comb begin
      nibble = 4'h0;
      legal  = 1'b1;
      case (seg)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/sseg_capture.sv
// Loopback monitor for a multiplexed four-digit seven-segment bus: synchronizes
// the pins, waits for a stable word, decodes it and holds the last value per digit.
module sseg_capture
   import sseg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT_W     = 16
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] an,
   input  logic [7:0] sseg,
   output logic [3:0] hex0,
   output logic [3:0] hex1,
   output logic [3:0] hex2,
   output logic [3:0] hex3,
   output logic [3:0] dp,
   output logic [3:0] digit_valid,
   output logic       frame_done,
   output logic       code_err,
   output logic       an_err
);

   logic [3:0]           an_p0, an_p1;
   logic [7:0]           sseg_p0, sseg_p1;
   logic [11:0]          word_p1, word_p2;
   logic [7:0]           stable_cnt;
   logic [TIMEOUT_W-1:0] idle_timer;
   logic [3:0]           seen;
   logic [3:0]           hex_q [4];

   logic                 strobe, one_cold, legal, valid_cap, bad_code, bad_an, timer_wrap;
   logic [3:0]           cap_an, sel, nibble;
   logic                 cap_dp;
   logic [3:0]           valid_nxt, seen_nxt;
   logic                 frame_nxt;

   // Stage p0/p1: two-flop synchronizer, blank on reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an_p0   <= AN_IDLE;
         an_p1   <= AN_IDLE;
         sseg_p0 <= 8'hFF;
         sseg_p1 <= 8'hFF;
      end else begin
         an_p0   <= an;
         an_p1   <= an_p0;
         sseg_p0 <= sseg;
         sseg_p1 <= sseg_p0;
      end
   end

   assign word_p1 = {an_p1, sseg_p1};

   // Stage p2: delayed copy and saturating stability counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_p2    <= 12'hFFF;
         stable_cnt <= 8'd0;
      end else begin
         word_p2 <= word_p1;
         if (word_p1 != word_p2)
            stable_cnt <= 8'd0;
         else if (stable_cnt != 8'(STABLE_CYCLES))
            stable_cnt <= stable_cnt + 8'd1;
      end
   end

   // Fires only on the edge where the counter steps into saturation
   assign strobe = (word_p1 == word_p2) && (stable_cnt == 8'(STABLE_CYCLES - 1));

   assign cap_an   = word_p1[11:8];
   assign cap_dp   = word_p1[7];
   assign sel      = ~cap_an;
   assign one_cold = is_one_cold(cap_an);

   seg7_to_hex u_dec (
      .seg    (word_p1[6:0]),
      .nibble (nibble),
      .legal  (legal)
   );

   assign valid_cap  = strobe && one_cold && legal;
   assign bad_code   = strobe && one_cold && !legal;
   assign bad_an     = strobe && !one_cold && (cap_an != AN_IDLE);
   assign timer_wrap = &idle_timer;

   // A valid capture in the wrap cycle takes precedence over the stale clear
   always_comb begin
      valid_nxt = digit_valid;
      seen_nxt  = seen;
      frame_nxt = 1'b0;
      if (valid_cap) begin
         valid_nxt = digit_valid | sel;
         if ((seen | sel) == 4'hF) begin
            frame_nxt = 1'b1;
            seen_nxt  = 4'h0;
         end else begin
            seen_nxt = seen | sel;
         end
      end else begin
         if (timer_wrap) begin
            valid_nxt = 4'h0;
            seen_nxt  = 4'h0;
         end
         if (bad_code)
            valid_nxt = valid_nxt & cap_an;
      end
   end

   // Stage p3: capture registers, frame/error pulses and idle timer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 4; k++) hex_q[k] <= 4'h0;
         dp          <= 4'b1111;
         digit_valid <= 4'h0;
         seen        <= 4'h0;
         idle_timer  <= '0;
         frame_done  <= 1'b0;
         code_err    <= 1'b0;
         an_err      <= 1'b0;
      end else begin
         if (valid_cap) begin
            for (int k = 0; k < 4; k++) begin
               if (sel[k]) begin
                  hex_q[k] <= nibble;
                  dp[k]    <= cap_dp;
               end
            end
            idle_timer <= '0;
         end else begin
            idle_timer <= idle_timer + TIMEOUT_W'(1);
         end
         digit_valid <= valid_nxt;
         seen        <= seen_nxt;
         frame_done  <= frame_nxt;
         code_err    <= bad_code;
         an_err      <= bad_an;
      end
   end

   assign hex0 = hex_q[0];
   assign hex1 = hex_q[1];
   assign hex2 = hex_q[2];
   assign hex3 = hex_q[3];

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture: reset, latency, clean scan, timeout,
// glitch rejection, illegal code and bad anode scenarios.
module tb_sseg_capture;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] an;
   logic [7:0] sseg;
   logic [3:0] hex0, hex1, hex2, hex3, dp, digit_valid;
   logic       frame_done, code_err, an_err;

   int checks = 0;
   int errors = 0;
   int fd_cnt = 0;
   int ce_cnt = 0;
   int ae_cnt = 0;

   sseg_capture #(.STABLE_CYCLES(4), .TIMEOUT_W(8)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .an          (an),
      .sseg        (sseg),
      .hex0        (hex0),
      .hex1        (hex1),
      .hex2        (hex2),
      .hex3        (hex3),
      .dp          (dp),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .code_err    (code_err),
      .an_err      (an_err)
   );

   always #5 clk = ~clk;

   // Pulses last one full cycle, so one sample per negedge counts each once
   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (code_err === 1'b1)   ce_cnt++;
      if (an_err === 1'b1)     ae_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      an      = 4'b1111;
      sseg    = 8'hFF;
      step(3);
      reset_n = 1'b1;
      step(10);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;
      an      = 4'b1111;
      sseg    = 8'hFF;
      step(3);
      checks++;
      if ({hex3, hex2, hex1, hex0} !== 16'h0000) begin
         errors++; $display("FAIL reset_hex got %h exp 0000", {hex3, hex2, hex1, hex0});
      end
      checks++;
      if (dp !== 4'b1111) begin
         errors++; $display("FAIL reset_dp got %b exp 1111", dp);
      end
      checks++;
      if ({digit_valid, frame_done, code_err, an_err} !== 7'b0) begin
         errors++; $display("FAIL reset_flags got %b exp 0000000",
                            {digit_valid, frame_done, code_err, an_err});
      end
      reset_n = 1'b1;
      step(10);
   endtask

   task automatic test_latency();
      an   = 4'b1110;
      sseg = {1'b0, 7'b0010010};
      step(6);
      checks++;
      if (hex0 !== 4'h0 || digit_valid !== 4'b0000) begin
         errors++; $display("FAIL latency_early got hex0=%h valid=%b exp 0/0000", hex0, digit_valid);
      end
      step(1);
      checks++;
      if (hex0 !== 4'h5 || digit_valid !== 4'b0001 || dp !== 4'b1110) begin
         errors++; $display("FAIL latency_update got hex0=%h valid=%b dp=%b exp 5/0001/1110",
                            hex0, digit_valid, dp);
      end
      an   = 4'b1101;
      sseg = {1'b1, 7'b1111000};
      step(3);
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (hex0 !== 4'h0 || hex1 !== 4'h0 || digit_valid !== 4'b0000 || dp !== 4'b1111) begin
         errors++; $display("FAIL reset_async got hex0=%h hex1=%h valid=%b dp=%b exp 0/0/0000/1111",
                            hex0, hex1, digit_valid, dp);
      end
      @(negedge clk);
      reset_n = 1'b1;
      step(6);
      checks++;
      if (hex1 !== 4'h0 || digit_valid !== 4'b0000) begin
         errors++; $display("FAIL post_reset_early got hex1=%h valid=%b exp 0/0000", hex1, digit_valid);
      end
      step(1);
      checks++;
      if (hex1 !== 4'h7 || digit_valid !== 4'b0010 || dp !== 4'b1111) begin
         errors++; $display("FAIL post_reset_update got hex1=%h valid=%b dp=%b exp 7/0010/1111",
                            hex1, digit_valid, dp);
      end
   endtask

   task automatic test_clean_frame();
      logic [3:0] an_tab   [4];
      logic [6:0] code_tab [4];
      logic       dp_tab   [4];
      int         fd0;
      an_tab   = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
      code_tab = '{7'b0110000, 7'b0001000, 7'b1000000, 7'b0001110};
      dp_tab   = '{1'b0, 1'b1, 1'b0, 1'b1};
      apply_reset();
      fd0 = fd_cnt;
      for (int s = 0; s < 2; s++) begin
         for (int d = 0; d < 4; d++) begin
            an   = an_tab[d];
            sseg = {dp_tab[d], code_tab[d]};
            step(256);
         end
         checks++;
         if (fd_cnt - fd0 !== s + 1) begin
            errors++; $display("FAIL frame_count got %0d exp %0d", fd_cnt - fd0, s + 1);
         end
      end
      checks++;
      if ({hex3, hex2, hex1, hex0} !== 16'h3A0F) begin
         errors++; $display("FAIL frame_hex got %h exp 3a0f", {hex3, hex2, hex1, hex0});
      end
      checks++;
      if (dp !== 4'b0101 || digit_valid !== 4'b1111) begin
         errors++; $display("FAIL frame_dp_valid got dp=%b valid=%b exp 0101/1111", dp, digit_valid);
      end
   endtask

   // Entered 249 cycles after the final digit's capture edge
   task automatic test_timeout();
      an = 4'b1111;
      step(6);
      checks++;
      if (digit_valid !== 4'b1111) begin
         errors++; $display("FAIL timeout_early got valid=%b exp 1111", digit_valid);
      end
      step(1);
      checks++;
      if (digit_valid !== 4'b0000) begin
         errors++; $display("FAIL timeout_clear got valid=%b exp 0000", digit_valid);
      end
      checks++;
      if ({hex3, hex2, hex1, hex0} !== 16'h3A0F || dp !== 4'b0101) begin
         errors++; $display("FAIL timeout_retain got hex=%h dp=%b exp 3a0f/0101",
                            {hex3, hex2, hex1, hex0}, dp);
      end
   endtask

   task automatic test_glitch();
      int ce0;
      an   = 4'b1110;
      sseg = {1'b1, 7'b0000000};
      step(20);
      checks++;
      if (hex0 !== 4'h8) begin
         errors++; $display("FAIL glitch_setup got hex0=%h exp 8", hex0);
      end
      ce0  = ce_cnt;
      sseg = {1'b1, 7'b1111001};
      step(2);
      sseg = {1'b1, 7'b0000000};
      step(20);
      checks++;
      if (hex0 !== 4'h8 || digit_valid[0] !== 1'b1) begin
         errors++; $display("FAIL glitch_hold got hex0=%h valid0=%b exp 8/1", hex0, digit_valid[0]);
      end
      checks++;
      if (ce_cnt - ce0 !== 0) begin
         errors++; $display("FAIL glitch_code_err got %0d exp 0", ce_cnt - ce0);
      end
   endtask

   task automatic test_illegal();
      int ce0;
      an   = 4'b1101;
      sseg = {1'b0, 7'b0000010};
      step(20);
      checks++;
      if (hex1 !== 4'h6 || digit_valid !== 4'b0011) begin
         errors++; $display("FAIL illegal_setup got hex1=%h valid=%b exp 6/0011", hex1, digit_valid);
      end
      ce0  = ce_cnt;
      sseg = {1'b1, 7'b1010101};
      step(20);
      checks++;
      if (ce_cnt - ce0 !== 1) begin
         errors++; $display("FAIL illegal_pulses got %0d exp 1", ce_cnt - ce0);
      end
      checks++;
      if (hex1 !== 4'h6 || digit_valid !== 4'b0001 || dp[1] !== 1'b0) begin
         errors++; $display("FAIL illegal_state got hex1=%h valid=%b dp1=%b exp 6/0001/0",
                            hex1, digit_valid, dp[1]);
      end
   endtask

   task automatic test_bad_anode();
      int ae0, ce0, fd0;
      ae0  = ae_cnt;
      ce0  = ce_cnt;
      fd0  = fd_cnt;
      an   = 4'b1100;
      sseg = {1'b0, 7'b0100100};
      step(20);
      checks++;
      if (ae_cnt - ae0 !== 1) begin
         errors++; $display("FAIL bad_an_pulses got %0d exp 1", ae_cnt - ae0);
      end
      checks++;
      if ({hex3, hex2, hex1, hex0} !== 16'h3A68 || digit_valid !== 4'b0001 || dp !== 4'b0101) begin
         errors++; $display("FAIL bad_an_state got hex=%h valid=%b dp=%b exp 3a68/0001/0101",
                            {hex3, hex2, hex1, hex0}, digit_valid, dp);
      end
      an = 4'b1111;
      step(20);
      checks++;
      if (ae_cnt - ae0 !== 1 || ce_cnt - ce0 !== 0 || fd_cnt - fd0 !== 0) begin
         errors++; $display("FAIL blank_pulses got an=%0d code=%0d frame=%0d exp 1/0/0",
                            ae_cnt - ae0, ce_cnt - ce0, fd_cnt - fd0);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      an      = 4'b1111;
      sseg    = 8'hFF;
      test_reset();
      test_latency();
      test_clean_frame();
      test_timeout();
      test_glitch();
      test_illegal();
      test_bad_anode();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sseg_capture.md
# sseg_capture

Receive-side monitor for the four-digit multiplexed seven-segment bus (active-low anodes `an`, active-low segments `sseg`). The block samples the bus asynchronously and waits for each anode/segment combination to settle. It then decodes the segment pattern back to a hex nibble and the decimal-point bit, and holds the last decoded value per digit. It sits in the ADC wing test design as a loopback checker on the display driver's output pins, and its results are readable by the test logic.

## Interface
- `STABLE_CYCLES`, default 4. Consecutive identical synchronized samples required before a capture; legal range 2–255.
- `TIMEOUT_W`, default 16. Width of the idle timer; 2^TIMEOUT_W cycles without a valid capture marks every digit stale.
- `clk`, input, 1. Single system clock; all logic is on the rising edge.
- `reset_n`, input, 1. Asynchronous, active-low reset.
- `an`, input, 4. Anode enables, active-low, asynchronous to `clk`. Bit k selects digit k.
- `sseg`, input, 8. Segments g..a in bits 6:0, active-low. Decimal point in bit 7, passed through raw.
- `hex0`..`hex3`, output, 4 each. Last valid decoded nibble per digit.
- `dp`, output, 4. Last captured raw `sseg[7]` per digit.
- `digit_valid`, output, 4. Bit k is set while `hex`k holds a fresh valid decode.
- `frame_done`, output, 1. One-cycle pulse when all four digits have been validly captured since the previous pulse.
- `code_err`, output, 1. One-cycle pulse when a captured `sseg[6:0]` is not a legal code.
- `an_err`, output, 1. One-cycle pulse when a captured `an` is neither one-cold nor `4'b1111`.

## Operation
- **Synchronizer:** `an` and `sseg` each pass through a two-flop synchronizer. Reset value is all ones (blank).
- **Stability counter:**
  - The synchronized word {an, sseg} is compared with its one-cycle-delayed copy.
  - Any difference clears the counter to 0. Otherwise the counter increments and saturates at `STABLE_CYCLES`.
  - The capture strobe fires on the single cycle the counter reaches `STABLE_CYCLES`. A word that stays stable longer produces exactly one strobe.
- **On the capture strobe:**
  - `an` = `4'b1111`: blank interval. No update, no error.
  - `an` one-cold at bit k, legal code: `hex`k gets the decoded nibble, `dp[k]` gets `sseg[7]`, `digit_valid[k]` is set, and bit k is set in the seen-mask.
  - `an` one-cold, illegal code: `code_err` pulses and `digit_valid[k]` is cleared. `hex`k and `dp[k]` keep their previous values.
  - Any other `an` value: `an_err` pulses. Nothing else changes.
- **Legal codes** for `sseg[6:0]`, hex 0–F in order:
  - 0–3: 1000000, 1111001, 0100100, 0110000
  - 4–7: 0011001, 0010010, 0000010, 1111000
  - 8–B: 0000000, 0010000, 0001000, 0000011
  - C–F: 1000110, 0100001, 0000110, 0001110
- **Frame tracking:** when the seen-mask becomes `4'b1111` (including the capture that completes it), `frame_done` pulses and the mask clears in the same cycle.
- **Idle timer:**
  - Counts up every cycle and restarts on every valid capture.
  - On wrap it clears `digit_valid` and the seen-mask. `hex` and `dp` are retained.
  - If a valid capture and the wrap occur in the same cycle, the capture wins and the timer restarts.
- **Reset values:** `hex0`..`hex3` = 0, `dp` = `4'b1111`, `digit_valid` = 0, `frame_done`/`code_err`/`an_err` = 0, seen-mask = 0, counters = 0.
- **Reset mid-scan:** all state clears. The first capture after reset release needs a full stability window.

## Timing
- Suppose the inputs change before edge t and then hold.
  - The synchronized value is visible after edge t+1.
  - The strobe is asserted combinationally in the cycle after edge t+1+`STABLE_CYCLES`.
  - All outputs update, registered, at edge t+2+`STABLE_CYCLES`. That is 6 cycles at the default.
- Glitches shorter than `STABLE_CYCLES` cycles after synchronization never capture.
- Error and frame pulses are exactly one cycle wide and aligned with the `hex`/`dp` register update.
- Output changes are not back-pressured. Downstream logic samples `frame_done`.

## Structure
- Package `sseg_pkg` holds:
  - the 16 segment-code constants (`SEG_0`..`SEG_F`);
  - `SEG_BLANK` = `7'h7F`;
  - `AN_IDLE` = `4'b1111`.
- Sub-module `seg7_to_hex`: purely combinational. Input `seg[6:0]`; outputs `nibble[3:0]` and `legal`. It lets the decode table be checked on its own.
- The top level contains the synchronizer, stability counter, capture registers, seen-mask and idle timer.

## Test plan
- **Clean frame:** drive a display-mux scan of digits 3,A,0,F with dp = `4'b0101`, 256 cycles per digit. Expect `hex3`=3, `hex2`=A, `hex1`=0, `hex0`=F, `dp`=`4'b0101`, `digit_valid`=`4'b1111`, and one `frame_done` per scan.
- **Glitch rejection:** hold `an`=`4'b1110` with code 8. Insert a 2-cycle glitch to code 1. Expect `hex0` stays 8, no `code_err`, and no extra capture.
- **Illegal code:** `an`=`4'b1101`, `sseg[6:0]`=`7'b1010101` for 20 cycles. Expect exactly one `code_err` pulse, `digit_valid[1]`=0, `hex1` unchanged.
- **Bad anode:** `an`=`4'b1100` stable for 20 cycles. Expect one `an_err` pulse and no output change. Then `an`=`4'b1111`: expect no pulses.
- **Latency and reset:** a single input change must update outputs exactly 6 cycles later (default parameter). Assert `reset_n` low mid-window: all outputs return to reset values immediately. After release, the next capture needs the full window.
- **Timeout:** with `TIMEOUT_W`=8, after a full frame hold `an`=`4'b1111`. Expect `digit_valid` to clear 256 cycles after the last capture while `hex` and `dp` are retained.
